// File: rtl/mc_control_if.sv
// Purpose : signal bundle between the multicycle controller and its datapath/memory.
// Latency : none, wires only.
// Backpressure: MemReady is the only stall input; the controller holds a memory request until it sees MemReady.
//
// Ports (master = controller side):
//   Opcode, MemReady                       -> into controller
//   PCWrite .. ALUSrcA (1b enables/selects) -> out of controller
//   RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource (2b selects) -> out of controller
//   State (4b debug), ErrCode (2b)          -> out of controller
interface mc_control_if;
    logic [5:0] Opcode;
    logic       MemReady;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       ALUSrcA;

    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;

    logic [3:0] State;
    logic [1:0] ErrCode;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
        output RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource,
        output State, ErrCode
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
        input  RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource,
        input  State, ErrCode
    );
endinterface

// File: rtl/mc_control.sv
// Purpose : multicycle MIPS-style control FSM (fetch/decode/execute/mem/writeback) with memory-wait timeout.
// Latency : R-type/addi/slti 4 cycles, lw 5, sw 4, beq/j/jal 3, plus one cycle per MemReady=0 wait.
// Backpressure: FETCH, MEMRD and MEMWR stall while MemReady=0; after TIMEOUT stalled cycles the FSM parks in ERR.
//
// Ports:
//   Clk      : single clock, rising edge
//   Reset_n  : synchronous active-low reset; also forces every output to 0 while low
//   bus      : mc_control_if.master (Opcode/MemReady in, datapath controls, State, ErrCode out)
// Parameters:
//   TIMEOUT        : max consecutive MemReady=0 cycles tolerated in a memory state, 0 = never time out
//   ILLEGAL_AS_NOP : 1 = unknown opcode returns to FETCH, 0 = unknown opcode parks in ERR
module mc_control #(
    parameter int TIMEOUT        = 15,
    parameter bit ILLEGAL_AS_NOP = 1'b0
) (
    input  logic         Clk,
    input  logic         Reset_n,
    mc_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        JMP    = 4'd9,
        IMMEX  = 4'd10,
        JALWB  = 4'd11,
        ERR    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] ALU_FUNCT = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_SLT   = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b11;

    // Counter only has to reach TIMEOUT; a disabled timeout still needs a 1-bit counter.
    localparam int             CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [5:0]      opreg;
    logic [1:0]      errcode;

    logic            wait_st;
    logic            mem_stall;
    logic            timeout_hit;

    // A memory-wait state that has not seen its completion strobe this cycle.
    assign wait_st     = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign mem_stall   = wait_st && !bus.MemReady;
    // MemReady=1 on the TIMEOUT-th count wins: the stall term is false, so no error.
    assign timeout_hit = (TIMEOUT > 0) && mem_stall && (wait_cnt == TMAX);

    // ------------------------------------------------------------------
    // State, wait counter, latched opcode and sticky error code
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
            opreg    <= '0;
            errcode  <= ERR_NONE;
        end else begin
            // Staying in a wait state only ever happens on a stall, so counting
            // stalls and clearing otherwise gives "cleared on entry" for free.
            if (mem_stall && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            case (state)
                FETCH: begin
                    if (bus.MemReady)
                        state <= DECODE;
                    else if (timeout_hit) begin
                        state   <= ERR;
                        errcode <= ERR_TIMEOUT;
                    end
                end

                DECODE: begin
                    opreg <= bus.Opcode;
                    case (bus.Opcode)
                        OP_LW, OP_SW:     state <= MEMADR;
                        OP_RTYPE:         state <= RTEX;
                        OP_BEQ:           state <= BEQ;
                        OP_J:             state <= JMP;
                        OP_JAL:           state <= JALWB;
                        OP_ADDI, OP_SLTI: state <= IMMEX;
                        default: begin
                            if (ILLEGAL_AS_NOP)
                                state <= FETCH;
                            else begin
                                state   <= ERR;
                                errcode <= ERR_ILLEGAL;
                            end
                        end
                    endcase
                end

                MEMADR: state <= (opreg == OP_LW) ? MEMRD : MEMWR;

                MEMRD: begin
                    if (bus.MemReady)
                        state <= MEMWB;
                    else if (timeout_hit) begin
                        state   <= ERR;
                        errcode <= ERR_TIMEOUT;
                    end
                end

                MEMWR: begin
                    if (bus.MemReady)
                        state <= FETCH;
                    else if (timeout_hit) begin
                        state   <= ERR;
                        errcode <= ERR_TIMEOUT;
                    end
                end

                RTEX, IMMEX:             state <= ALUWB;
                MEMWB, ALUWB, BEQ, JMP,
                JALWB:                   state <= FETCH;

                // Only reset leaves ERR.
                ERR:                     state <= ERR;

                // Unused encodings recover to a clean fetch.
                default:                 state <= FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control decode. Combinational from the state register because
    // IRWrite/PCWrite in FETCH must follow MemReady in the same cycle and
    // everything must drop to 0 the moment Reset_n goes low.
    // ------------------------------------------------------------------
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.RegDst      = 2'b00;
        bus.MemtoReg    = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.State       = state;
        bus.ErrCode     = errcode;

        case (state)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = ALU_ADD;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ALUOp   = ALU_ADD;
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = ALU_ADD;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'b01;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            RTEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
            end
            IMMEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = (opreg == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = (opreg == OP_RTYPE) ? 2'b01 : 2'b00;
            end
            BEQ: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            JMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            JALWB: begin
                bus.RegDst   = 2'b10;
                bus.MemtoReg = 2'b10;
                bus.RegWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            default: ; // ERR and unused encodings: all enables low
        endcase

        if (!Reset_n) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.IorD        = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.ALUSrcA     = 1'b0;
            bus.RegDst      = 2'b00;
            bus.MemtoReg    = 2'b00;
            bus.ALUSrcB     = 2'b00;
            bus.ALUOp       = 2'b00;
            bus.PCSource    = 2'b00;
            bus.State       = 4'd0;
            bus.ErrCode     = 2'b00;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Purpose : directed-vector bench for mc_control (two parameterisations side by side).
// Latency : n/a.
// Backpressure: MemReady driven directly from the vectors.
module tb_mc_control;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_a;
    logic rst_b;

    mc_control_if ia ();
    mc_control_if ib ();

    mc_control #(.TIMEOUT(3),  .ILLEGAL_AS_NOP(1'b0)) dut_a (.Clk(Clk), .Reset_n(rst_a), .bus(ia));
    mc_control #(.TIMEOUT(15), .ILLEGAL_AS_NOP(1'b1)) dut_b (.Clk(Clk), .Reset_n(rst_b), .bus(ib));

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,ALUSrcA,RegDst,MemtoReg,ALUSrcB,ALUOp,PCSource}
    wire [17:0] ctl_a = {ia.PCWrite, ia.PCWriteCond, ia.IorD, ia.MemRead, ia.MemWrite, ia.IRWrite,
                         ia.RegWrite, ia.ALUSrcA, ia.RegDst, ia.MemtoReg, ia.ALUSrcB, ia.ALUOp, ia.PCSource};
    wire [17:0] ctl_b = {ib.PCWrite, ib.PCWriteCond, ib.IorD, ib.MemRead, ib.MemWrite, ib.IRWrite,
                         ib.RegWrite, ib.ALUSrcA, ib.RegDst, ib.MemtoReg, ib.ALUSrcB, ib.ALUOp, ib.PCSource};

    function automatic logic [17:0] ctl(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw,  input logic irw,  input logic rw,   input logic asa,
        input logic [1:0] rd, input logic [1:0] mtr, input logic [1:0] asb,
        input logic [1:0] aop, input logic [1:0] pcs);
        return {pcw, pcwc, iord, mr, mw, irw, rw, asa, rd, mtr, asb, aop, pcs};
    endfunction

    //                                      pcw   pcwc  iord  mr    mw    irw   rw    asa   rd     mtr    asb    aop    pcs
    localparam logic [17:0] C_ZERO       = 18'd0;
    localparam logic [17:0] C_FETCH_RDY  = ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00);
    localparam logic [17:0] C_FETCH_WAIT = ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00);
    localparam logic [17:0] C_DECODE     = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00);
    localparam logic [17:0] C_MEMADR     = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00);
    localparam logic [17:0] C_MEMRD      = ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    localparam logic [17:0] C_MEMWB      = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    localparam logic [17:0] C_MEMWR      = ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    localparam logic [17:0] C_RTEX       = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    localparam logic [17:0] C_ALUWB_R    = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    localparam logic [17:0] C_ALUWB_I    = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    localparam logic [17:0] C_IMMEX_SLT  = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00);
    localparam logic [17:0] C_BEQ        = ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    localparam logic [17:0] C_JMP        = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    localparam logic [17:0] C_JALWB      = ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10);

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic exp_a(input string tag, input logic [3:0] st, input logic [17:0] c, input logic [1:0] ec);
        #1;
        chk({tag, ".state"}, {28'd0, ia.State},   {28'd0, st});
        chk({tag, ".ctl"},   {14'd0, ctl_a},      {14'd0, c});
        chk({tag, ".err"},   {30'd0, ia.ErrCode}, {30'd0, ec});
    endtask

    task automatic exp_b(input string tag, input logic [3:0] st, input logic [17:0] c, input logic [1:0] ec);
        #1;
        chk({tag, ".state"}, {28'd0, ib.State},   {28'd0, st});
        chk({tag, ".ctl"},   {14'd0, ctl_b},      {14'd0, c});
        chk({tag, ".err"},   {30'd0, ib.ErrCode}, {30'd0, ec});
    endtask

    initial begin
        rst_a       = 1'b0;
        rst_b       = 1'b0;
        ia.Opcode   = 6'h23;
        ia.MemReady = 1'b0;
        ib.Opcode   = 6'h00;
        ib.MemReady = 1'b0;
        tick();
        tick();

        // Outputs stay 0 while held in reset even with MemReady high.
        ia.MemReady = 1'b1;
        exp_a("rst_hold", 4'd0, C_ZERO, 2'b00);

        // lw with MemReady tied high: 0,1,2,3,4,0
        rst_a = 1'b1;
        exp_a("lw_fetch",  4'd0, C_FETCH_RDY, 2'b00);
        tick(); exp_a("lw_decode", 4'd1, C_DECODE,    2'b00);
        tick(); exp_a("lw_memadr", 4'd2, C_MEMADR,    2'b00);
        tick(); exp_a("lw_memrd",  4'd3, C_MEMRD,     2'b00);
        tick(); exp_a("lw_memwb",  4'd4, C_MEMWB,     2'b00);
        tick(); exp_a("lw_done",   4'd0, C_FETCH_RDY, 2'b00);

        // slti
        ia.Opcode = 6'h0a;
        tick(); exp_a("slti_decode", 4'd1,  C_DECODE,    2'b00);
        tick(); exp_a("slti_immex",  4'd10, C_IMMEX_SLT, 2'b00);
        tick(); exp_a("slti_aluwb",  4'd7,  C_ALUWB_I,   2'b00);
        tick();

        // R-type
        ia.Opcode = 6'h00;
        tick(); tick(); exp_a("r_rtex",  4'd6, C_RTEX,    2'b00);
        tick();         exp_a("r_aluwb", 4'd7, C_ALUWB_R, 2'b00);
        tick();

        // beq
        ia.Opcode = 6'h04;
        tick(); tick(); exp_a("beq", 4'd8, C_BEQ, 2'b00);
        tick();

        // j
        ia.Opcode = 6'h02;
        tick(); tick(); exp_a("j", 4'd9, C_JMP, 2'b00);
        tick();

        // jal
        ia.Opcode = 6'h03;
        tick(); tick(); exp_a("jal",      4'd11, C_JALWB,     2'b00);
        tick();         exp_a("jal_done", 4'd0,  C_FETCH_RDY, 2'b00);

        // lw interrupted by reset during MEMRD
        ia.Opcode = 6'h23;
        tick(); tick(); tick();
        exp_a("lw2_memrd", 4'd3, C_MEMRD, 2'b00);
        rst_a = 1'b0;
        exp_a("rst_mid_low", 4'd0, C_ZERO, 2'b00);
        tick();
        exp_a("rst_mid_after", 4'd0, C_ZERO, 2'b00);

        // FETCH timeout with TIMEOUT=3: four FETCH cycles, then ERR/10
        ia.MemReady = 1'b0;
        rst_a       = 1'b1;
        exp_a("tmo_f1", 4'd0, C_FETCH_WAIT, 2'b00);
        tick(); exp_a("tmo_f2", 4'd0, C_FETCH_WAIT, 2'b00);
        tick(); exp_a("tmo_f3", 4'd0, C_FETCH_WAIT, 2'b00);
        tick(); exp_a("tmo_f4", 4'd0, C_FETCH_WAIT, 2'b00);
        tick(); exp_a("tmo_err", 4'd12, C_ZERO, 2'b10);
        ia.MemReady = 1'b1;
        tick(); tick();
        exp_a("tmo_sticky", 4'd12, C_ZERO, 2'b10);
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        exp_a("tmo_clear", 4'd0, C_FETCH_RDY, 2'b00);

        // sw completing on the 4th MEMWR cycle (counter == TIMEOUT, MemReady=1)
        ia.Opcode = 6'h2b;
        tick(); tick(); tick();
        ia.MemReady = 1'b0;
        exp_a("sw_w1", 4'd5, C_MEMWR, 2'b00);
        tick(); exp_a("sw_w2", 4'd5, C_MEMWR, 2'b00);
        tick(); exp_a("sw_w3", 4'd5, C_MEMWR, 2'b00);
        tick();
        ia.MemReady = 1'b1;
        exp_a("sw_w4", 4'd5, C_MEMWR, 2'b00);
        tick(); exp_a("sw_done", 4'd0, C_FETCH_RDY, 2'b00);

        // illegal opcode, ILLEGAL_AS_NOP=0
        ia.Opcode = 6'h3f;
        tick(); tick(); exp_a("ill_err",    4'd12, C_ZERO, 2'b01);
        tick();         exp_a("ill_sticky", 4'd12, C_ZERO, 2'b01);
        rst_a = 1'b0;
        tick();

        // second instance: ILLEGAL_AS_NOP=1, TIMEOUT=15
        rst_b       = 1'b1;
        ib.MemReady = 1'b1;
        ib.Opcode   = 6'h3f;
        exp_b("b_fetch", 4'd0, C_FETCH_RDY, 2'b00);
        tick(); exp_b("b_decode", 4'd1, C_DECODE,    2'b00);
        tick(); exp_b("b_nop",    4'd0, C_FETCH_RDY, 2'b00);

        ib.MemReady = 1'b0;
        repeat (15) tick();
        exp_b("b_tmo_edge", 4'd0,  C_FETCH_WAIT, 2'b00);
        tick();
        exp_b("b_tmo_err",  4'd12, C_ZERO,       2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
